fp_operand_issuer: RTL and testbench
====================================

# fp_operand_issuer

Operand issue stage upstream of the FPU exception checker. It buffers incoming 32-bit single-precision operands in a small FIFO and presents them one at a time on the checker's Data/Data_valid/ACK handshake. It captures the checker's Exc code on ACK and returns operand plus normalized exception code on a valid/ready result port. It also enforces the checker's mandatory idle cycle between requests.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT, 16, cycles to wait for ACK before forcing a timeout result (used only with the timeout macro); ≥2
- CLK  input  1  clock, all state updates on posedge
- RSTN  input  1  reset; one clock; reset is asynchronous and active-low
- In_data  input  32  operand to enqueue
- In_valid  input  1  In_data valid
- In_ready  output  1  FIFO not full; push occurs when In_valid & In_ready at posedge
- Data  output  32  FIFO head to checker; 32'h0 when Data_valid=0
- Data_valid  output  1  request to checker; high only in state REQ
- ACK  input  1  checker acknowledge, sampled at posedge while in REQ
- Exc  input  3  checker exception code, valid in the cycle ACK=1
- Res_data  output  32  operand that was checked
- Res_exc  output  3  3'b011 infinity, 3'b100 NaN, 3'b000 normal, 3'b111 timeout
- Res_valid  output  1  result held until Res_ready
- Res_ready  input  1  consumer accepts result when Res_valid & Res_ready at posedge

## Operation
- FIFO: DEPTH entries, wrapping read/write pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits. In_ready = (count != DEPTH), purely from registered count.
- Push and pop in the same cycle leave count unchanged. When full, no push occurs even if a pop happens that cycle.
- Result slot: one register set {Res_data, Res_exc, Res_valid}. It is cleared (Res_valid→0) on Res_valid & Res_ready.
- FSM states:
  - IDLE: if count≠0 and slot free (Res_valid=0, or being consumed this cycle), go to REQ; otherwise stay.
  - REQ: Data_valid=1, Data=FIFO head. On ACK=1: load Res_data=head, set Res_valid=1, pop FIFO, go to GAP.
  - GAP: Data_valid=0 for exactly one cycle so the checker returns to Compute, then go to IDLE.
- Exc normalization on capture: 3'b011→3'b011, 3'b100→3'b100, any other value→3'b000.
- An ACK seen in IDLE or GAP is ignored and has no effect on any state.
- Reset, from any state including mid-REQ:
  - FSM→IDLE; FIFO empty (pointers and count 0).
  - In_ready=1, Data_valid=0, Data=0, Res_valid=0, Res_data=0, Res_exc=0.
  - An operand in flight is discarded.

## Timing
- Push at edge t into an empty FIFO with the slot free: FSM enters REQ at edge t+1, so Data_valid=1 in cycle t+1.
- ACK high in cycle k (sampled at edge k+1): Res_valid=1 and Data_valid=0 from cycle k+1. GAP occupies cycle k+1. The earliest next REQ is cycle k+3.
- Peak throughput is one operand per 3 cycles when ACK returns in the first REQ cycle.
- Res_valid rises only from a capture. Back-pressure on Res_ready stalls issue in IDLE and never drops a result.

## Configuration
- FPISSUE_TIMEOUT_EN defined:
  - A counter clears on entering REQ and increments every REQ cycle without ACK.
  - If ACK is still 0 in the TIMEOUT-th REQ cycle, capture Res_exc=3'b111 with Res_data=head, pop, and go to GAP.
  - ACK in that same cycle takes priority and yields the normalized Exc.
- Undefined: no counter logic; REQ waits for ACK indefinitely.

## Test plan
- Reset mid-REQ with 2 operands queued → all outputs reach reset values immediately; In_ready=1; no result is emitted after RSTN rises.
- Push 32'h7F800000, ACK one cycle after Data_valid with Exc=3'b011 → Res_data=32'h7F800000, Res_exc=3'b011; Data_valid low for exactly one GAP cycle.
- Push 32'h7FC00000 (Exc=3'b100), then 32'h3F800000 (checker drives a stale 3'b100 with ACK) → results 3'b100, then 3'b000 only if the checker drives 3'b000; stale 3'b101 normalizes to 3'b000. Order is preserved.
- Fill DEPTH=4 with Res_ready=0 → In_ready=0 after 4 pushes. After the first result is captured, no further REQ occurs until Res_ready=1. Push and pop in the same cycle at count 3 keeps count 3.
- With FPISSUE_TIMEOUT_EN and ACK tied 0 → result Res_exc=3'b111 after 16 REQ cycles; the FIFO advances to the next operand.
- Spurious ACK=1 in IDLE and GAP → no pop and no result.

Source files
------------

// File: rtl/fp_operand_issuer.sv
// Operand issuer: buffers FP32 operands and issues them to the exception checker.
// Ports: In_* enqueue, Data/Data_valid/ACK/Exc checker side, Res_* result; FPISSUE_TIMEOUT_EN adds ACK timeout.
module fp_operand_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] In_data,
  input  logic        In_valid,
  output logic        In_ready,
  output logic [31:0] Data,
  output logic        Data_valid,
  input  logic        ACK,
  input  logic [2:0]  Exc,
  output logic [31:0] Res_data,
  output logic [2:0]  Res_exc,
  output logic        Res_valid,
  input  logic        Res_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_operand_issuer: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2) begin : g_bad_tmo
    $error("fp_operand_issuer: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [31:0]   r_res_data;
  logic [2:0]    r_res_exc;
  logic          r_res_valid;

  logic          w_push;
  logic          w_nonempty;
  logic          w_res_take;
  logic          w_slot_free;
  logic          w_ack;
  logic          w_tmo;
  logic          w_capture;
  logic          w_req;
  logic [31:0]   w_head;
  logic [2:0]    w_exc_norm;
  logic [2:0]    w_exc_nxt;

  assign In_ready    = (r_count != FULL);
  assign w_push      = In_valid & In_ready;
  assign w_nonempty  = (r_count != '0);
  assign w_head      = r_mem[r_rptr];
  assign w_res_take  = r_res_valid & Res_ready;
  // slot counts as free when its current result leaves this cycle
  assign w_slot_free = ~r_res_valid | w_res_take;
  assign w_ack       = (r_state == S_REQ) & ACK;
  assign w_capture   = w_ack | w_tmo;

`ifdef FPISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;

  // held at zero outside REQ, so it starts from zero on REQ entry
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_tcnt <= '0;
    end else if (r_state != S_REQ) begin
      r_tcnt <= '0;
    end else if (!ACK) begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // r_tcnt == TIMEOUT-1 marks the TIMEOUT-th REQ cycle; ACK wins
  assign w_tmo = (r_state == S_REQ) && !ACK &&
                 (r_tcnt == TW'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_exc_norm = 3'b000;
    unique case (Exc)
      3'b011:  w_exc_norm = 3'b011;
      3'b100:  w_exc_norm = 3'b100;
      default: w_exc_norm = 3'b000;
    endcase
  end

  assign w_exc_nxt = w_ack ? w_exc_norm : 3'b111;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_nonempty && w_slot_free) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_req = 1'b1;
        if (w_capture) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign Data_valid = w_req;
  assign Data       = w_req ? w_head : 32'h0;

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= In_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_capture) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_capture})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_res_data  <= 32'h0;
      r_res_exc   <= 3'b000;
      r_res_valid <= 1'b0;
    end else if (w_capture) begin
      r_res_data  <= w_head;
      r_res_exc   <= w_exc_nxt;
      r_res_valid <= 1'b1;
    end else if (w_res_take) begin
      r_res_valid <= 1'b0;
    end
  end

  assign Res_data  = r_res_data;
  assign Res_exc   = r_res_exc;
  assign Res_valid = r_res_valid;

endmodule

// File: tb/tb_fp_operand_issuer.sv
// Directed bench for fp_operand_issuer: vector table plus
// hand sequences for throughput, back-pressure, spurious ACK, reset.
module tb_fp_operand_issuer;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [31:0] In_data = 32'h0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [31:0] Data;
  logic        Data_valid;
  logic        ACK = 1'b0;
  logic [2:0]  Exc = 3'b000;
  logic [31:0] Res_data;
  logic [2:0]  Res_exc;
  logic        Res_valid;
  logic        Res_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  fp_operand_issuer #(.DEPTH(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
    .Data(Data), .Data_valid(Data_valid),
    .ACK(ACK), .Exc(Exc),
    .Res_data(Res_data), .Res_exc(Res_exc),
    .Res_valid(Res_valid), .Res_ready(Res_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] act,
                      input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (Data_valid) break;
      tick();
    end
    chk1({nm, "_req_seen"}, Data_valid, 1'b1);
  endtask

  task automatic capture(input string nm, input logic [31:0] d,
                         input logic [2:0] e, input logic [2:0] x);
    wait_req(nm);
    chk32({nm, "_data"}, Data, d);
    ACK = 1'b1;
    Exc = e;
    tick();
    ACK = 1'b0;
    Exc = 3'b000;
    chk1({nm, "_res_valid"}, Res_valid, 1'b1);
    chk32({nm, "_res_data"}, Res_data, d);
    chk3({nm, "_res_exc"}, Res_exc, x);
    chk1({nm, "_gap"}, Data_valid, 1'b0);
  endtask

  task automatic push(input logic [31:0] d);
    In_data = d;
    In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] d;
    logic [2:0]  exc;
    logic [2:0]  exp;
    int          dly;
  } vec_t;

  vec_t tv[8];

  initial begin
    logic seen;
    int   n;

    tv[0] = '{32'h7F800000, 3'b011, 3'b011, 1};
    tv[1] = '{32'h7FC00000, 3'b100, 3'b100, 0};
    tv[2] = '{32'h3F800000, 3'b100, 3'b100, 2};
    tv[3] = '{32'h3F800000, 3'b000, 3'b000, 0};
    tv[4] = '{32'h12345678, 3'b101, 3'b000, 3};
    tv[5] = '{32'hFF800000, 3'b011, 3'b011, 0};
    tv[6] = '{32'h00000001, 3'b111, 3'b000, 1};
    tv[7] = '{32'h7F800001, 3'b100, 3'b100, 0};

    tick();
    tick();
    chk1("rst_in_ready", In_ready, 1'b1);
    chk1("rst_data_valid", Data_valid, 1'b0);
    chk32("rst_data", Data, 32'h0);
    chk1("rst_res_valid", Res_valid, 1'b0);
    chk32("rst_res_data", Res_data, 32'h0);
    chk3("rst_res_exc", Res_exc, 3'b000);
    RSTN = 1'b1;

    for (int i = 0; i < 8; i++) begin
      push(tv[i].d);
      chk1("vec_pre_req", Data_valid, 1'b0);
      chk32("vec_idle_data", Data, 32'h0);
      tick();
      chk1("vec_req", Data_valid, 1'b1);
      chk32("vec_head", Data, tv[i].d);
      for (int k = 0; k < tv[i].dly; k++) begin
        tick();
        chk1("vec_req_hold", Data_valid, 1'b1);
      end
      ACK = 1'b1;
      Exc = tv[i].exc;
      tick();
      ACK = 1'b0;
      Exc = 3'b101;
      chk1("vec_res_valid", Res_valid, 1'b1);
      chk32("vec_res_data", Res_data, tv[i].d);
      chk3("vec_res_exc", Res_exc, tv[i].exp);
      chk1("vec_gap", Data_valid, 1'b0);
      Res_ready = 1'b1;
      tick();
      Res_ready = 1'b0;
      chk1("vec_consumed", Res_valid, 1'b0);
      chk1("vec_idle", Data_valid, 1'b0);
    end
    Exc = 3'b000;

    // back-to-back: next REQ exactly in cycle k+3
    In_data = 32'hAAAA0001;
    In_valid = 1'b1;
    tick();
    In_data = 32'hAAAA0002;
    tick();
    In_valid = 1'b0;
    chk1("b2b_req1", Data_valid, 1'b1);
    chk32("b2b_head1", Data, 32'hAAAA0001);
    ACK = 1'b1;
    Exc = 3'b100;
    tick();
    ACK = 1'b0;
    chk32("b2b_res1", Res_data, 32'hAAAA0001);
    chk3("b2b_exc1", Res_exc, 3'b100);
    chk1("b2b_gap", Data_valid, 1'b0);
    Res_ready = 1'b1;
    tick();
    chk1("b2b_idle", Data_valid, 1'b0);
    chk1("b2b_taken", Res_valid, 1'b0);
    tick();
    chk1("b2b_req2", Data_valid, 1'b1);
    chk32("b2b_head2", Data, 32'hAAAA0002);
    ACK = 1'b1;
    Exc = 3'b101;
    tick();
    ACK = 1'b0;
    Exc = 3'b000;
    chk32("b2b_res2", Res_data, 32'hAAAA0002);
    chk3("b2b_exc2", Res_exc, 3'b000);
    tick();
    Res_ready = 1'b0;
    tick();

    // fill to full with result back-pressure
    for (int j = 0; j < 4; j++) push(32'hB0000000 + 32'(j));
    chk1("full_not_ready", In_ready, 1'b0);
    push(32'hDEADBEEF);
    chk1("full_still", In_ready, 1'b0);
    capture("bp_a0", 32'hB0000000, 3'b011, 3'b011);
    chk1("bp_ready_after_pop", In_ready, 1'b1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk1("bp_stall_noreq", Data_valid, 1'b0);
      chk1("bp_hold_res", Res_valid, 1'b1);
    end
    chk32("bp_hold_data", Res_data, 32'hB0000000);
    Res_ready = 1'b1;
    tick();
    Res_ready = 1'b0;
    chk1("bp_released", Res_valid, 1'b0);
    chk1("bp_req_a1", Data_valid, 1'b1);
    chk32("bp_head_a1", Data, 32'hB0000001);
    In_data = 32'hB0000004;
    In_valid = 1'b1;
    ACK = 1'b1;
    Exc = 3'b100;
    tick();
    ACK = 1'b0;
    Exc = 3'b000;
    chk32("pp_res", Res_data, 32'hB0000001);
    chk3("pp_exc", Res_exc, 3'b100);
    chk1("pp_count3", In_ready, 1'b1);
    In_data = 32'hB0000005;
    Res_ready = 1'b1;
    tick();
    In_valid = 1'b0;
    chk1("pp_count4", In_ready, 1'b0);
    capture("dr_a2", 32'hB0000002, 3'b000, 3'b000);
    capture("dr_a3", 32'hB0000003, 3'b100, 3'b100);
    capture("dr_a4", 32'hB0000004, 3'b011, 3'b011);
    capture("dr_a5", 32'hB0000005, 3'b110, 3'b000);
    repeat (4) tick();
    chk1("dr_empty", Data_valid, 1'b0);
    chk1("dr_no_res", Res_valid, 1'b0);

    // spurious ACK in IDLE and GAP
    ACK = 1'b1;
    Exc = 3'b011;
    repeat (3) tick();
    chk1("sp_idle_nores", Res_valid, 1'b0);
    chk1("sp_idle_noreq", Data_valid, 1'b0);
    ACK = 1'b0;
    push(32'hC0000001);
    tick();
    chk1("sp_req", Data_valid, 1'b1);
    ACK = 1'b1;
    Exc = 3'b100;
    tick();
    chk1("sp_cap", Res_valid, 1'b1);
    tick();
    chk1("sp_gap_nores", Res_valid, 1'b0);
    repeat (3) tick();
    chk1("sp_after_nores", Res_valid, 1'b0);
    chk1("sp_after_noreq", Data_valid, 1'b0);
    chk1("sp_in_ready", In_ready, 1'b1);
    ACK = 1'b0;
    Exc = 3'b000;
    push(32'hC0000002);
    capture("sp_next", 32'hC0000002, 3'b011, 3'b011);
    tick();
    Res_ready = 1'b0;
    tick();

`ifdef FPISSUE_TIMEOUT_EN
    In_data = 32'hE0000001;
    In_valid = 1'b1;
    tick();
    In_data = 32'hE0000002;
    tick();
    In_valid = 1'b0;
    wait_req("tmo");
    n = 0;
    while (!Res_valid && n < 40) begin
      tick();
      n++;
    end
    chk32("tmo_cycles", 32'(n), 32'd16);
    chk3("tmo_exc", Res_exc, 3'b111);
    chk32("tmo_data", Res_data, 32'hE0000001);
    Res_ready = 1'b1;
    capture("tmo_next", 32'hE0000002, 3'b011, 3'b011);
    tick();
    Res_ready = 1'b0;
    tick();
`endif

    // reset in the middle of REQ with two operands queued
    In_data = 32'hF0000001;
    In_valid = 1'b1;
    tick();
    In_data = 32'hF0000002;
    tick();
    In_valid = 1'b0;
    chk1("mr_in_req", Data_valid, 1'b1);
    ACK = 1'b1;
    Exc = 3'b011;
    #2;
    RSTN = 1'b0;
    #1;
    chk1("mr_in_ready", In_ready, 1'b1);
    chk1("mr_data_valid", Data_valid, 1'b0);
    chk32("mr_data", Data, 32'h0);
    chk1("mr_res_valid", Res_valid, 1'b0);
    chk32("mr_res_data", Res_data, 32'h0);
    chk3("mr_res_exc", Res_exc, 3'b000);
    tick();
    tick();
    RSTN = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      seen = seen | Res_valid | Data_valid;
    end
    chk1("mr_no_result", seen, 1'b0);
    ACK = 1'b0;
    Exc = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
